data_bus_responder: RTL and testbench

- Responder end of the core's data bus (bus_address / bus_wr_data / bus_read_data / bus_write_length / bus_wr_enable).
- Contains the data RAM, a small MMIO register bank (GPIO, fault status) and a sticky fault monitor for illegal stores.
- Reads are combinational, so the single-cycle core completes a load in the same cycle. Writes commit on the rising clock edge.

---
 rtl/data_bus_responder_if.sv | 19 +
 rtl/data_bus_responder.sv | 147 ++++++++++++++
 tb/tb_data_bus_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_responder_if.sv
// Data bus between the core (master) and the data-side responder (slave).
// Carries the byte address, store data/length/strobe and the combinational load data.
interface data_bus_responder_if;
    logic [31:0] bus_address;
    logic [31:0] bus_wr_data;
    logic [2:0]  bus_write_length;
    logic        bus_wr_enable;
    logic [31:0] bus_read_data;

    modport master (
        output bus_address, bus_wr_data, bus_write_length, bus_wr_enable,
        input  bus_read_data
    );

    modport slave (
        input  bus_address, bus_wr_data, bus_write_length, bus_wr_enable,
        output bus_read_data
    );
endinterface

// File: rtl/data_bus_responder.sv
// Data RAM, GPIO/fault MMIO bank and sticky illegal-store monitor on the core's data bus.
// Optional macro BUS_RESPONDER_TIMER_EN adds a free-running 64-bit counter with a snapshot register.
module data_bus_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned GPIO_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_bus_responder_if.slave   bus,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  fault,
    output logic [31:0]           fault_addr
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [2:0] {
        LEN_B = 3'b000,
        LEN_H = 3'b001,
        LEN_W = 3'b010
    } len_e;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [1:0]       lane;
    logic [IDX_W-1:0] word_idx;
    logic             ram_hit;
    logic             sel_gpio, sel_fault, sel_fault_addr;
    logic             sel_snap, sel_snap_hi;
    logic             len_ok, align_ok;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_shift;
    logic             ram_store_ok, mmio_store_ok;
    logic             ram_we, store_illegal;
    logic [31:0]      read_data;

`ifdef BUS_RESPONDER_TIMER_EN
    logic [63:0] cnt;
    logic [63:0] shadow;
    assign sel_snap    = (bus.bus_address == MMIO_BASE + 32'h10);
    assign sel_snap_hi = (bus.bus_address == MMIO_BASE + 32'h14);
`else
    assign sel_snap    = 1'b0;
    assign sel_snap_hi = 1'b0;
`endif

    assign lane           = bus.bus_address[1:0];
    assign word_idx       = bus.bus_address[IDX_W+1:2];
    assign ram_hit        = ({1'b0, bus.bus_address} < RAM_BYTES);
    // Exact-address decode: a misaligned MMIO access hits no register at all.
    assign sel_gpio       = (bus.bus_address == MMIO_BASE);
    assign sel_fault      = (bus.bus_address == MMIO_BASE + 32'h4);
    assign sel_fault_addr = (bus.bus_address == MMIO_BASE + 32'h8);
    assign wdata_shift    = bus.bus_wr_data << {lane, 3'b000};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        len_ok   = 1'b0;
        align_ok = 1'b0;
        byte_en  = 4'b0000;
        case (bus.bus_write_length)
            LEN_B: begin
                len_ok   = 1'b1;
                align_ok = 1'b1;
                byte_en  = 4'b0001 << lane;
            end
            LEN_H: begin
                len_ok   = 1'b1;
                align_ok = ~lane[0];
                byte_en  = 4'b0011 << lane;
            end
            LEN_W: begin
                len_ok   = 1'b1;
                align_ok = (lane == 2'b00);
                byte_en  = 4'b1111;
            end
            default: ;
        endcase
        ram_store_ok  = ram_hit && len_ok && align_ok;
        // FAULT_ADDR and the snapshot high word are read-only, so they are not store targets.
        mmio_store_ok = sel_gpio || sel_fault || sel_snap;
        ram_we        = bus.bus_wr_enable && ram_store_ok;
        store_illegal = bus.bus_wr_enable && !(ram_store_ok || mmio_store_ok);
    end

    always_comb begin
        read_data = '0;
        if (ram_hit)
            read_data = mem[word_idx] >> {lane, 3'b000};
        else if (sel_gpio)
            read_data = 32'(gpio_out);
        else if (sel_fault)
            read_data = {31'b0, fault};
        else if (sel_fault_addr)
            read_data = fault_addr;
`ifdef BUS_RESPONDER_TIMER_EN
        else if (sel_snap)
            read_data = shadow[31:0];
        else if (sel_snap_hi)
            read_data = shadow[63:32];
`endif
    end

    assign bus.bus_read_data = read_data;

    // NOTE: the RAM array has no reset; only control state is cleared by rst_n.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && byte_en[i])
                mem[word_idx][8*i +: 8] <= wdata_shift[8*i +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out   <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (bus.bus_wr_enable) begin
            if (store_illegal) begin
                if (!fault) begin
                    fault      <= 1'b1;
                    fault_addr <= bus.bus_address;
                end
            end else begin
                if (sel_gpio)
                    gpio_out <= bus.bus_wr_data[GPIO_WIDTH-1:0];
                if (sel_fault)
                    fault <= 1'b0;
            end
        end
    end

`ifdef BUS_RESPONDER_TIMER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else begin
            cnt <= cnt + 64'd1;
            if (bus.bus_wr_enable && sel_snap)
                shadow <= cnt;
        end
    end
`endif
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder: lanes, faults, MMIO, async reset
// and, when BUS_RESPONDER_TIMER_EN is defined, the counter snapshot.
module tb_data_bus_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0]  gpio_out;
    logic        fault;
    logic [31:0] fault_addr;
    logic [63:0] cyc;
    logic [63:0] exp_snap;
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    data_bus_responder_if bus_if ();

    data_bus_responder #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (MMIO),
        .GPIO_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.slave),
        .gpio_out   (gpio_out),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    // Independent edge count since reset release; equals the DUT counter between edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 64'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
        @(negedge clk);
        bus_if.bus_address      = a;
        bus_if.bus_wr_data      = d;
        bus_if.bus_write_length = len;
        bus_if.bus_wr_enable    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_wr_enable    = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus_if.bus_address   = a;
        bus_if.bus_wr_enable = 1'b0;
        #1;
        check(tag, bus_if.bus_read_data, exp);
    endtask

    initial begin
        bus_if.bus_address      = '0;
        bus_if.bus_wr_data      = '0;
        bus_if.bus_write_length = 3'b010;
        bus_if.bus_wr_enable    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gpio", 32'(gpio_out), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_addr", fault_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte and word lanes
        store(32'h100, 32'hDEADBEEF, 3'b010);
        store(32'h102, 32'h00000055, 3'b000);
        read_check("sb_word", 32'h100, 32'hDE55BEEF);
        read_check("sb_shift2", 32'h102, 32'h0000DE55);
        read_check("sb_shift1", 32'h101, 32'h00DE55BE);

        // Half and top-byte lanes; upper store bits must be ignored
        store(32'h200, 32'hAAAAAAAA, 3'b010);
        store(32'h202, 32'hFFFF1234, 3'b001);
        read_check("sh_upper", 32'h200, 32'h1234AAAA);
        check("sh_no_fault", 32'(fault), 32'h0);
        store(32'h203, 32'h000000C3, 3'b000);
        read_check("sb_lane3", 32'h200, 32'hC334AAAA);

        // Last RAM word
        store(32'hFFC, 32'h13579BDF, 3'b010);
        read_check("ram_last", 32'hFFC, 32'h13579BDF);

        // Read during write returns the old word, new word after the edge
        @(negedge clk);
        bus_if.bus_address      = 32'h100;
        bus_if.bus_wr_data      = 32'h0BADF00D;
        bus_if.bus_write_length = 3'b010;
        bus_if.bus_wr_enable    = 1'b1;
        #1;
        check("rdw_old", bus_if.bus_read_data, 32'hDE55BEEF);
        @(posedge clk);
        #1;
        bus_if.bus_wr_enable = 1'b0;
        check("rdw_new", bus_if.bus_read_data, 32'h0BADF00D);

        // Misaligned SW faults and leaves RAM unchanged
        store(32'h104, 32'hCAFEF00D, 3'b010);
        store(32'h105, 32'h12345678, 3'b010);
        read_check("misal_ram", 32'h104, 32'hCAFEF00D);
        check("misal_fault", 32'(fault), 32'h1);
        check("misal_addr", fault_addr, 32'h105);
        read_check("mmio_fault_rd", MMIO + 32'h4, 32'h1);
        read_check("mmio_faddr_rd", MMIO + 32'h8, 32'h105);

        // Second fault keeps the first address
        store(32'h301, 32'h0000FFFF, 3'b001);
        check("sticky_addr", fault_addr, 32'h105);

        // Clear
        store(MMIO + 32'h4, 32'h0, 3'b010);
        check("clear_fault", 32'(fault), 32'h0);
        check("clear_keeps_addr", fault_addr, 32'h105);

        // Unmapped RAM end
        store(32'h1000, 32'h11111111, 3'b010);
        check("unmapped_fault", 32'(fault), 32'h1);
        check("unmapped_addr", fault_addr, 32'h1000);
        store(MMIO + 32'h4, 32'h0, 3'b000);
        check("clear_sb", 32'(fault), 32'h0);

        // Illegal length
        store(32'h0, 32'h5A5A5A5A, 3'b010);
        store(32'h0, 32'hFFFFFFFF, 3'b011);
        check("badlen_fault", 32'(fault), 32'h1);
        check("badlen_addr", fault_addr, 32'h0);
        read_check("badlen_ram", 32'h0, 32'h5A5A5A5A);

        // Misaligned write to FAULT does not clear
        store(MMIO + 32'h5, 32'h0, 3'b010);
        check("misal_clear", 32'(fault), 32'h1);
        check("misal_clear_addr", fault_addr, 32'h0);
        store(MMIO + 32'h4, 32'h0, 3'b010);
        check("clear2", 32'(fault), 32'h0);

        // FAULT_ADDR is read-only
        store(MMIO + 32'h8, 32'h12345678, 3'b010);
        check("ro_fault", 32'(fault), 32'h1);
        check("ro_addr", fault_addr, MMIO + 32'h8);
        store(MMIO + 32'h4, 32'h0, 3'b010);

        // Unmapped reads
        read_check("rd_unmapped_mmio", MMIO + 32'h20, 32'h0);
        read_check("rd_unmapped_ram", 32'h1000, 32'h0);

        // GPIO
        store(MMIO, 32'h000001A5, 3'b010);
        check("gpio_sw", 32'(gpio_out), 32'hA5);
        read_check("gpio_rd", MMIO, 32'h000000A5);
        store(MMIO, 32'h0000003C, 3'b000);
        check("gpio_sb", 32'(gpio_out), 32'h3C);
        check("gpio_no_fault", 32'(fault), 32'h0);

        // Asynchronous reset mid-cycle
        store(32'h1000, 32'h0, 3'b010);
        check("pre_rst_fault", 32'(fault), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gpio", 32'(gpio_out), 32'h0);
        check("async_fault", 32'(fault), 32'h0);
        check("async_faddr", fault_addr, 32'h0);
        read_check("ram_survives", 32'h100, 32'h0BADF00D);
        read_check("ram_survives2", 32'h200, 32'hC334AAAA);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BUS_RESPONDER_TIMER_EN
        repeat (100) @(posedge clk);
        @(negedge clk);
        exp_snap = cyc;
        bus_if.bus_address      = MMIO + 32'h10;
        bus_if.bus_wr_data      = 32'h0;
        bus_if.bus_write_length = 3'b010;
        bus_if.bus_wr_enable    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.bus_wr_enable = 1'b0;
        check("snap_no_fault", 32'(fault), 32'h0);
        read_check("snap_lo", MMIO + 32'h10, exp_snap[31:0]);
        read_check("snap_hi", MMIO + 32'h14, 32'h0);
        repeat (5) @(posedge clk);
        read_check("snap_stable", MMIO + 32'h10, exp_snap[31:0]);
        store(MMIO + 32'h14, 32'h0, 3'b010);
        check("snap_hi_ro", 32'(fault), 32'h1);
        check("snap_hi_addr", fault_addr, MMIO + 32'h14);
`else
        store(MMIO + 32'h10, 32'h0, 3'b010);
        check("no_timer_fault", 32'(fault), 32'h1);
        check("no_timer_addr", fault_addr, MMIO + 32'h10);
        read_check("no_timer_rd", MMIO + 32'h10, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
